// File: rtl/rmii_tx.sv
// RMII transmitter: frames a valid/ready byte stream into preamble, SFD, payload,
// zero padding and CRC-32 FCS, one dibit per clock, then holds the inter-frame gap.
module rmii_tx #(
  parameter int BYTE_LEN   = 8,
  parameter int MIN_BYTES  = 60,
  parameter int IFG_CYCLES = 48
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [BYTE_LEN-1:0] in,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic                txen,
  output logic [1:0]          txd,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int DPB   = BYTE_LEN / 2;
  localparam int DIB_W = (DPB > 1) ? $clog2(DPB) : 1;
  localparam int CNT_W = 16;
  localparam logic [31:0]      POLY = 32'hEDB88320;
  localparam logic [CNT_W-1:0] MINB = CNT_W'(MIN_BYTES);

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     bcnt;
  logic [DIB_W-1:0]     dib;
  logic                 last_seen;
  logic [BYTE_LEN-1:0]  sh;
  logic [31:0]          crc;
  logic [31:0]          crc_nxt;
  logic [31:0]          fcs_sh;
  logic                 pre_end;
  logic                 byte_end;
  logic                 accept;
  logic                 underflow;
  logic                 pad_more;
  logic [CNT_W:0]       pad_left;

  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // state/counters describe the dibit currently on txd
  assign pre_end   = (state == PREAMBLE) && (cnt == CNT_W'(31));
  assign byte_end  = (dib == DIB_W'(DPB - 1));
  assign in_ready  = pre_end || ((state == PAYLOAD) && byte_end && !last_seen);
  assign accept    = in_ready && in_valid;
  assign underflow = in_ready && !in_valid;
  assign pad_left  = {1'b0, MINB} - {1'b0, bcnt};
  assign pad_more  = !pad_left[CNT_W] && (pad_left != '0);
  assign crc_nxt   = crc_dibit(crc, txd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      dib       <= '0;
      last_seen <= 1'b0;
      txen      <= 1'b0;
      txd       <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (underflow) begin
        state <= IFG;
        txen  <= 1'b0;
        txd   <= 2'b00;
        err   <= 1'b1;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            state <= PREAMBLE;
            txen  <= 1'b1;
            txd   <= 2'b01;
            busy  <= 1'b1;
            cnt   <= '0;
          end
          PREAMBLE: if (!pre_end) begin
            cnt <= cnt + CNT_W'(1);
            txd <= (cnt == CNT_W'(30)) ? 2'b11 : 2'b01;
          end else begin
            state     <= PAYLOAD;
            txd       <= in[1:0];
            dib       <= '0;
            last_seen <= in_last;
            bcnt      <= CNT_W'(1);
          end
          PAYLOAD, PAD: if (!byte_end) begin
            dib <= dib + DIB_W'(1);
            txd <= sh[1:0];
          end else if (accept) begin
            txd       <= in[1:0];
            dib       <= '0;
            last_seen <= in_last;
            bcnt      <= sat_inc(bcnt);
          end else if (pad_more) begin
            state <= PAD;
            txd   <= 2'b00;
            dib   <= '0;
            bcnt  <= sat_inc(bcnt);
          end else begin
            // FCS is the complement of the CRC including the dibit now leaving
            state <= FCS;
            txd   <= ~crc_nxt[1:0];
            cnt   <= '0;
          end
          FCS: if (cnt == CNT_W'(15)) begin
            state <= IFG;
            txen  <= 1'b0;
            txd   <= 2'b00;
            done  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            txd <= fcs_sh[1:0];
          end
          IFG: if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // datapath registers carry no reset; control decides when they matter
  always_ff @(posedge clk) begin
    sh <= accept ? (in >> 2) : (sh >> 2);
    if (state == IDLE)
      crc <= '1;
    else if (state == PAYLOAD || state == PAD)
      crc <= crc_nxt;
    fcs_sh <= (state == FCS) ? (fcs_sh >> 2) : ((~crc_nxt) >> 2);
  end

endmodule

// File: tb/tb_rmii_tx.sv
// Scoreboard bench for rmii_tx: a frame-level model pushes expected dibits and frame
// endings into per-DUT queues; monitors pop and compare as the DUTs transmit.
module tb_rmii_tx;

  localparam int IFG = 48;

  logic            clk;
  logic [1:0]      rstn;
  logic [1:0][7:0] din;
  logic [1:0]      vld;
  logic [1:0]      last;
  wire  [1:0]      rdy;
  wire  [1:0]      txen;
  wire  [1:0][1:0] txd;
  wire  [1:0]      busy;
  wire  [1:0]      done;
  wire  [1:0]      err;

  int tests = 0;
  int fails = 0;

  logic [1:0] exp_q  [2][$];
  int         len_q  [2][$];
  int         kind_q [2][$];
  bit         ign    [2];
  bit         gap_chk[2];
  logic [7:0] fb[$];
  logic [31:0] fcs_fix;
  bit          use_fix;

  rmii_tx #(.MIN_BYTES(0)) dut0 (
    .clk(clk), .rstn(rstn[0]), .in(din[0]), .in_valid(vld[0]), .in_last(last[0]),
    .in_ready(rdy[0]), .txen(txen[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0])
  );

  rmii_tx #(.MIN_BYTES(60)) dut1 (
    .clk(clk), .rstn(rstn[1]), .in(din[1]), .in_valid(vld[1]), .in_last(last[1]),
    .in_ready(rdy[1]), .txen(txen[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got unexpected event, expected none", nm);
  endtask

  task automatic push_byte(input int d, input logic [7:0] b);
    for (int k = 0; k < 4; k++) exp_q[d].push_back(b[2*k +: 2]);
  endtask

  // Frame model: preamble/SFD, payload (+ zero pad), complemented reflected CRC-32.
  // uf >= 0 means the frame is abandoned after uf bytes.
  task automatic expect_frame(input int d, input int n, input int uf);
    int minb;
    int nb;
    logic [7:0] b;
    logic [31:0] c;
    minb = (d == 0) ? 0 : 60;
    for (int k = 0; k < 31; k++) exp_q[d].push_back(2'b01);
    exp_q[d].push_back(2'b11);
    nb = (uf >= 0) ? uf : ((n > minb) ? n : minb);
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < nb; k++) begin
      b = (k < n) ? fb[k] : 8'h00;
      push_byte(d, b);
      for (int bi = 0; bi < 8; bi++)
        c = (c[0] ^ b[bi]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    if (uf < 0) begin
      c = use_fix ? fcs_fix : ~c;
      for (int k = 0; k < 4; k++) push_byte(d, c[8*k +: 8]);
      len_q[d].push_back(32 + 4*nb + 16);
      kind_q[d].push_back(0);
    end else begin
      len_q[d].push_back(32 + 4*nb);
      kind_q[d].push_back(1);
    end
  endtask

  task automatic monitor(input int g);
    int burst = 0;
    int low_run = 0;
    int ifg_n = 0;
    int len;
    int kind;
    bit prev = 0;
    bit in_ifg = 0;
    bit fall;
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (!rstn[g] || ign[g]) begin
        burst = 0; low_run = 0; prev = 0; in_ifg = 0;
        continue;
      end
      fall = prev && !txen[g];
      kind = -1;
      if (txen[g]) begin
        if (!prev) begin
          if (gap_chk[g]) begin
            chk("b2b_gap", low_run, IFG + 1);
            gap_chk[g] = 0;
          end
          burst = 0;
        end
        burst++;
        if (exp_q[g].size() == 0) bad("extra_dibit");
        else begin
          e = exp_q[g].pop_front();
          chk("txd", 32'(txd[g]), 32'(e));
        end
      end else begin
        chk("idle_txd", 32'(txd[g]), 0);
        low_run = fall ? 1 : low_run + 1;
        if (fall) begin
          if (len_q[g].size() == 0) bad("extra_frame");
          else begin
            len  = len_q[g].pop_front();
            kind = kind_q[g].pop_front();
            chk("frame_len", burst, len);
          end
          in_ifg = 1;
          ifg_n  = 1;
        end else if (in_ifg) begin
          if (busy[g]) ifg_n++;
          else begin
            chk("ifg_len", ifg_n, IFG);
            in_ifg = 0;
          end
        end
      end
      chk("done", 32'(done[g]), 32'(kind == 0));
      chk("err", 32'(err[g]), 32'(kind == 1));
      prev = txen[g];
    end
  endtask

  task automatic send_frame(input int d, input int n, input int uf,
                            input bit chk_start, input bit wait_end);
    int i = 0;
    int guard = 0;
    int rdy_cnt = 0;
    bit acc;
    bit aborted = 0;
    expect_frame(d, n, uf);
    use_fix = 0;
    if (chk_start) begin @(posedge clk); #1; end
    vld[d] = 1'b1; din[d] = fb[0]; last[d] = (n == 1);
    while (i < n && !aborted) begin
      @(negedge clk);
      if (chk_start && guard < 2) chk("start_txen", 32'(txen[d]), 32'(guard == 1));
      guard++;
      if (guard > 5000) begin bad("send_timeout"); break; end
      acc = 0;
      if (rdy[d]) begin
        rdy_cnt++;
        if (uf >= 0 && i == uf) begin
          vld[d] = 1'b0; last[d] = 1'b0; aborted = 1;
        end else acc = 1;
      end
      @(posedge clk); #1;
      if (acc) begin
        i++;
        if (i < n) begin din[d] = fb[i]; last[d] = (i == n - 1); end
        else begin vld[d] = 1'b0; last[d] = 1'b0; end
      end
    end
    if (wait_end) begin
      guard = 0;
      do begin
        @(negedge clk);
        if (rdy[d]) rdy_cnt++;
        guard++;
      end while (busy[d] && guard < 3000);
      chk("busy_falls", 32'(busy[d]), 0);
      chk("rdy_pulses", rdy_cnt, aborted ? uf + 1 : n);
    end
  endtask

  task automatic rand_frame(input int n);
    fb.delete();
    for (int k = 0; k < n; k++) fb.push_back(8'($urandom));
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    int g;
    logic a;
    rstn = 2'b00; vld = '0; last = '0; din = '0;
    ign[0] = 0; ign[1] = 0; gap_chk[0] = 0; gap_chk[1] = 0; use_fix = 0; fcs_fix = '0;
    #25;
    for (int d = 0; d < 2; d++) begin
      chk("rst_txen", 32'(txen[d]), 0);
      chk("rst_txd", 32'(txd[d]), 0);
      chk("rst_busy", 32'(busy[d]), 0);
      chk("rst_rdy", 32'(rdy[d]), 0);
      chk("rst_done_err", 32'({done[d], err[d]}), 0);
    end
    #10 rstn = 2'b11;

    // single byte, no padding
    fb.delete(); fb.push_back(8'hA5);
    send_frame(0, 1, -1, 1, 1);

    // known-answer FCS for "123456789"
    fb.delete();
    for (int k = 0; k < 9; k++) fb.push_back(8'(8'h31 + k));
    fcs_fix = 32'hCBF43926; use_fix = 1;
    send_frame(0, 9, -1, 1, 1);

    for (int r = 0; r < 3; r++) begin
      rand_frame(int'($urandom_range(1, 20)));
      send_frame(0, fb.size(), -1, 1, 1);
    end

    // short frame padded to 60 bytes
    rand_frame(3);
    send_frame(1, 3, -1, 1, 1);

    for (int r = 0; r < 4; r++) begin
      rand_frame(int'($urandom_range(1, 90)));
      send_frame(1, fb.size(), -1, 1, 1);
    end

    // underflow after byte 5, then a normal frame
    rand_frame(10);
    send_frame(1, 10, 5, 1, 1);
    rand_frame(int'($urandom_range(50, 70)));
    send_frame(1, fb.size(), -1, 1, 1);

    // reset during payload
    ign[1] = 1;
    vld[1] = 1'b1; din[1] = 8'($urandom); last[1] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); a = rdy[1];
      @(posedge clk); #1;
      if (a) din[1] = 8'($urandom);
    end
    chk("pre_rst_txen", 32'(txen[1]), 1);
    #3 rstn[1] = 1'b0;
    #1;
    chk("mid_rst_txen", 32'(txen[1]), 0);
    chk("mid_rst_txd", 32'(txd[1]), 0);
    chk("mid_rst_busy", 32'(busy[1]), 0);
    chk("mid_rst_rdy", 32'(rdy[1]), 0);
    chk("mid_rst_done_err", 32'({done[1], err[1]}), 0);
    vld[1] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rstn[1] = 1'b1;
    exp_q[1].delete(); len_q[1].delete(); kind_q[1].delete();
    ign[1] = 0;
    rand_frame(int'($urandom_range(1, 30)));
    send_frame(1, fb.size(), -1, 1, 1);

    // back-to-back: next frame requested during the IFG
    rand_frame(4);
    send_frame(1, 4, -1, 0, 0);
    g = 0;
    do begin @(negedge clk); g++; end while (txen[1] && g < 2000);
    chk("b2b_fall_seen", 32'(txen[1]), 0);
    gap_chk[1] = 1;
    rand_frame(int'($urandom_range(60, 80)));
    send_frame(1, fb.size(), -1, 0, 1);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("dibits_left", exp_q[d].size(), 0);
      chk("frames_left", len_q[d].size(), 0);
    end
    chk("gap_checked", 32'(gap_chk[1]), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
